// File: rtl/mips_regfile_if.sv
// Register-file access bundle: one write port, two read ports and the commit counter.
interface mips_regfile_if;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic [7:0]  wr_count;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b, wr_count
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b, wr_count
    );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 MIPS register file, r0 hard-wired to zero, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module mips_regfile (
    input logic            clk,
    input logic            rst_n,
    mips_regfile_if.slave  bus
);

    typedef enum logic {StIdle, StCommit} state_e;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [7:0]  wr_count_q, wr_count_d;
    logic [1:0]  rst_sync_q;
    state_e      state_q, state_d;
    logic        commit;

    // Stage 0 opens the write port on the second edge after release; stage 1 frees the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign commit = bus.we && (bus.waddr != 5'd0) && rst_sync_q[0];

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[bus.waddr] = bus.wdata;
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (commit) begin
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    always_comb begin
        state_d = StIdle;
        unique case (state_q)
            StIdle:   if (commit) state_d = StCommit;
            StCommit: if (commit) state_d = StCommit;
            default:  state_d = StIdle;
        endcase
        if (!rst_sync_q[1]) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
            wr_count_q <= 8'h00;
            state_q    <= StIdle;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        bus.rdata_a = 32'h0000_0000;
        bus.rdata_b = 32'h0000_0000;
        if (rst_n) begin
            if (bus.raddr_a != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
                if (commit && (bus.raddr_a == bus.waddr)) begin
                    bus.rdata_a = bus.wdata;
                end else begin
                    bus.rdata_a = regs_q[bus.raddr_a];
                end
`else
                bus.rdata_a = regs_q[bus.raddr_a];
`endif
            end
            if (bus.raddr_b != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
                if (commit && (bus.raddr_b == bus.waddr)) begin
                    bus.rdata_b = bus.wdata;
                end else begin
                    bus.rdata_b = regs_q[bus.raddr_b];
                end
`else
                bus.rdata_b = regs_q[bus.raddr_b];
`endif
            end
        end
    end

    assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_mips_regfile.sv
// Directed self-checking bench for mips_regfile; expectations follow REGFILE_BYPASS_EN.
module tb_mips_regfile;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [7:0] exp_cnt;

    mips_regfile_if rf_if ();

    mips_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        rf_if.we    = 1'b1;
        rf_if.waddr = addr;
        rf_if.wdata = data;
        @(posedge clk);
        #1;
        rf_if.we = 1'b0;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        exp_cnt         = 8'h00;
        rst_n           = 1'b0;
        rf_if.we        = 1'b0;
        rf_if.waddr     = 5'd0;
        rf_if.wdata     = 32'h0;
        rf_if.raddr_a   = 5'd0;
        rf_if.raddr_b   = 5'd0;

        // Writes during reset are ignored.
        rf_if.raddr_a = 5'd4;
        rf_if.raddr_b = 5'd4;
        do_write(5'd4, 32'h1111_2222);
        do_write(5'd4, 32'h1111_2222);
        check("rst_rd_a", rf_if.rdata_a, 32'h0);
        check("rst_rd_b", rf_if.rdata_b, 32'h0);
        check("rst_cnt", {24'h0, rf_if.wr_count}, 32'h0);

        // Release just after an edge: edge 1 rejects, edge 2 accepts.
        rst_n = 1'b1;
        rf_if.raddr_a = 5'd9;
        do_write(5'd9, 32'h0000_0055);
        check("sync_edge1_rd", rf_if.rdata_a, 32'h0);
        check("sync_edge1_cnt", {24'h0, rf_if.wr_count}, 32'h0);
        do_write(5'd9, 32'h0000_0055);
        exp_cnt++;
        check("sync_edge2_rd", rf_if.rdata_a, 32'h0000_0055);
        check("sync_edge2_cnt", {24'h0, rf_if.wr_count}, {24'h0, exp_cnt});

        // Basic write, both ports same index.
        do_write(5'd7, 32'h1234_5678);
        exp_cnt++;
        rf_if.raddr_a = 5'd7;
        rf_if.raddr_b = 5'd7;
        #1;
        check("basic_a", rf_if.rdata_a, 32'h1234_5678);
        check("basic_b", rf_if.rdata_b, 32'h1234_5678);
        check("basic_cnt", {24'h0, rf_if.wr_count}, {24'h0, exp_cnt});

        // Write to r0 is discarded.
        do_write(5'd0, 32'hFFFF_FFFF);
        rf_if.raddr_a = 5'd0;
        #1;
        check("r0_rd", rf_if.rdata_a, 32'h0);
        check("r0_cnt", {24'h0, rf_if.wr_count}, {24'h0, exp_cnt});

        // Same-cycle read of the written index.
        do_write(5'd3, 32'h0000_000A);
        exp_cnt++;
        rf_if.raddr_a = 5'd3;
        rf_if.we      = 1'b1;
        rf_if.waddr   = 5'd3;
        rf_if.wdata   = 32'h0000_000B;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("fwd_same_cycle", rf_if.rdata_a, 32'h0000_000B);
`else
        check("fwd_same_cycle", rf_if.rdata_a, 32'h0000_000A);
`endif
        @(posedge clk);
        #1;
        rf_if.we = 1'b0;
        exp_cnt++;
        check("fwd_after_edge", rf_if.rdata_a, 32'h0000_000B);

        // we=0 leaves everything alone.
        rf_if.waddr = 5'd3;
        rf_if.wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        check("we0_rd", rf_if.rdata_a, 32'h0000_000B);
        check("we0_cnt", {24'h0, rf_if.wr_count}, {24'h0, exp_cnt});

        // Full sweep.
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i) * 32'h0101_0101);
            exp_cnt++;
        end
        for (int i = 0; i < 32; i++) begin
            rf_if.raddr_a = 5'(i);
            rf_if.raddr_b = 5'(31 - i);
            #1;
            check($sformatf("sweep_a%0d", i), rf_if.rdata_a, 32'(i) * 32'h0101_0101);
            check($sformatf("sweep_b%0d", 31 - i), rf_if.rdata_b,
                  32'(31 - i) * 32'h0101_0101);
        end
        check("sweep_cnt", {24'h0, rf_if.wr_count}, {24'h0, exp_cnt});

        // Mid-run reset clears without a clock edge.
        do_write(5'd5, 32'hDEAD_BEEF);
        rf_if.raddr_a = 5'd5;
        #1;
        check("pre_rst_r5", rf_if.rdata_a, 32'hDEAD_BEEF);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_r5", rf_if.rdata_a, 32'h0);
        check("midrst_cnt", {24'h0, rf_if.wr_count}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_r5", rf_if.rdata_a, 32'h0);
        @(posedge clk);
        #1;

        // Counter wrap.
        for (int i = 0; i < 256; i++) begin
            do_write(5'd1, 32'(i));
        end
        check("wrap_256", {24'h0, rf_if.wr_count}, 32'h0);
        do_write(5'd2, 32'h0000_0101);
        check("wrap_257", {24'h0, rf_if.wr_count}, 32'h1);
        rf_if.raddr_a = 5'd1;
        rf_if.raddr_b = 5'd2;
        #1;
        check("wrap_r1", rf_if.rdata_a, 32'h0000_00FF);
        check("wrap_r2", rf_if.rdata_b, 32'h0000_0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_regfile.md
MIPS_REGFILE -- requirements
Module: mips_regfile

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed: 32 registers, 32-bit data, 5-bit addresses.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port we, input, 1 bit: write enable for the write port.
REQ-005 The module SHALL have port waddr, input, 5 bits: write register index.
REQ-006 The module SHALL have port wdata, input, 32 bits: write data.
REQ-007 The module SHALL have port raddr_a, input, 5 bits: read port A index.
REQ-008 The module SHALL have port raddr_b, input, 5 bits: read port B index.
REQ-009 The module SHALL have port rdata_a, output, 32 bits: port A data, which drives ALU operand a.
REQ-010 The module SHALL have port rdata_b, output, 32 bits: port B data, which drives ALU operand b.
REQ-011 The module SHALL have port wr_count, output, 8 bits: count of committed writes, wrapping.

Function
REQ-012 The module SHALL hold 32 architectural registers r0..r31, each 32 bits wide.
REQ-013 Read ports A and B SHALL be combinational from address to data, with zero-cycle latency and no clock dependence.
REQ-014 Ports A and B SHALL be independent, with no conflict when raddr_a == raddr_b.
REQ-015 A read of index 0 on either port SHALL return 32'h00000000 under all conditions.
REQ-016 The module SHALL perform a write when we=1 at a rising clk edge: r[waddr] <= wdata.
REQ-017 A write to index 0 SHALL be discarded: r0 is unchanged and wr_count does not increment.
REQ-018 When we=0, no register SHALL change and wr_count SHALL hold.
REQ-019 wr_count SHALL increment by 1 on each committed write (we=1, waddr!=0).
REQ-020 wr_count SHALL wrap from 8'hFF to 8'h00 with no flag.
REQ-021 Write-back sequencing SHALL be a two-state machine: IDLE/COMMIT.
- IDLE -> COMMIT on a rising edge with a committed write.
- COMMIT -> IDLE on the next edge unless another committed write occurs.
- The state is internal and has no externally visible behaviour other than wr_count.
REQ-022 When a read and a write target the same index in the same cycle, the read SHALL be governed by the configuration in REQ-028/REQ-029.
REQ-023 Registers not addressed by waddr SHALL never change on a write.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately, without a clock, clear r1..r31 to 32'h00000000, set wr_count to 8'h00 and set the state to IDLE.
REQ-025 While rst_n=0, writes SHALL be ignored and rdata_a/rdata_b SHALL read 32'h00000000.
REQ-026 Reset deassertion SHALL be synchronised internally (2-flop) so that the first write is accepted on the second rising edge after rst_n rises.
REQ-027 Reset asserted in the same cycle as a write SHALL win: the write is lost and wr_count remains 0.

Configuration
REQ-028 With macro REGFILE_BYPASS_EN defined, write-to-read forwarding SHALL apply.
- Condition: we=1, waddr!=0 and raddr_x == waddr in the same cycle.
- Result: rdata_x returns wdata combinationally, before the edge.
REQ-029 With REGFILE_BYPASS_EN undefined, a same-cycle read SHALL return the old register value; the new value is visible from the cycle after the edge.

Verification
REQ-030 The bench SHALL cover reset: rst_n=0 mid-run after writing r5=32'hDEADBEEF -> rdata_a=0 for raddr_a=5 without a clock edge, and wr_count=0.
REQ-031 The bench SHALL cover a basic write: write r7=32'h12345678, then raddr_a=7, raddr_b=7 -> both ports read 32'h12345678 and wr_count=1.
REQ-032 The bench SHALL cover a write to r0: write r0=32'hFFFFFFFF -> raddr_a=0 reads 0 and wr_count unchanged.
REQ-033 The bench SHALL cover same-cycle forwarding: r3 holds 32'hA, then we=1, waddr=3, wdata=32'hB with raddr_a=3.
- With REGFILE_BYPASS_EN: rdata_a=32'hB in that cycle.
- Without it: rdata_a=32'hA in that cycle and 32'hB after the edge.
REQ-034 The bench SHALL cover counter wrap: 256 committed writes -> wr_count=8'h00.
- A 257th committed write -> wr_count=8'h01.
REQ-035 The bench SHALL cover the full sweep: write r[i]=i*32'h01010101 for i=1..31, then read all pairs (i, 31-i) -> exact values on both ports, with index 0 returning 0.
